pipe_reg_chain: RTL

- Parametrised successor to the single flip-flop register: a chain of DEPTH registers, each WIDTH bits wide, with a valid/ready handshake.
- Per-stage valid tracking, bubble collapsing, synchronous flush and an occupancy count.
- Used as the generic delay/retiming element between datapath blocks in the sequential_circuits library.

---
 rtl/pipe_reg_chain_pkg.sv | 19 +
 rtl/pipe_reg_chain_stage.sv | 48 ++++
 rtl/pipe_reg_chain.sv | 93 +++++++++
 3 files changed

// File: rtl/pipe_reg_chain_pkg.sv
// Shared definitions for the pipe_reg_chain family: default reset value and the
// ceil-log2 helper used to size the occupancy counter.
package pipe_reg_chain_pkg;

  localparam int unsigned DefaultResetVal = 0;

  // Smallest n with 2**n >= value; returns 0 for value <= 1.
  function automatic int unsigned seq_clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pipe_reg_chain_stage.sv
// One valid-tracked data register of the chain. Loads on rdy_i, clears valid on
// flush, data only changes when a valid word arrives.
module pipe_reg_chain_stage
  import pipe_reg_chain_pkg::*;
#(
  parameter int unsigned       WIDTH     = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL = WIDTH'(DefaultResetVal)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             rdy_i,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] data_o
);

  logic             vld_d, vld_q;
  logic [WIDTH-1:0] data_d, data_q;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (flush_i) begin
      vld_d = 1'b0;
    end else if (rdy_i) begin
      vld_d = vld_i;
      if (vld_i) begin
        data_d = data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q  <= 1'b0;
      data_q <= RESET_VAL;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;

endmodule

// File: rtl/pipe_reg_chain.sv
// Chain of DEPTH valid/ready register stages with bubble collapsing, synchronous
// flush and a registered occupancy count.
module pipe_reg_chain
  import pipe_reg_chain_pkg::*;
#(
  parameter int unsigned       WIDTH     = 8,
  parameter int unsigned       DEPTH     = 4,
  parameter logic [WIDTH-1:0]  RESET_VAL = WIDTH'(DefaultResetVal),
  parameter int unsigned       CNT_W     = seq_clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic [CNT_W-1:0] count
);

  logic [DEPTH-1:0]            vld;
  logic [DEPTH-1:0]            rdy;
  logic [DEPTH-1:0]            vld_in;
  logic [DEPTH-1:0][WIDTH-1:0] data;
  logic [DEPTH-1:0][WIDTH-1:0] data_in;
  logic                        accept;
  logic                        pop;
  logic [CNT_W-1:0]            count_d, count_q;

  // A stage is ready if it is empty or everything downstream of it can move.
  always_comb begin
    rdy            = '0;
    rdy[DEPTH-1]   = out_ready | ~vld[DEPTH-1];
    for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
      rdy[i] = rdy[i+1] | ~vld[i];
    end
  end

  always_comb begin
    vld_in     = '0;
    data_in    = '0;
    vld_in[0]  = in_valid;
    data_in[0] = in_data;
    for (int i = 1; i < int'(DEPTH); i++) begin
      vld_in[i]  = vld[i-1];
      data_in[i] = data[i-1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    pipe_reg_chain_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk_i   (clk),
      .rst_ni  (rst),
      .flush_i (flush),
      .rdy_i   (rdy[g]),
      .vld_i   (vld_in[g]),
      .data_i  (data_in[g]),
      .vld_o   (vld[g]),
      .data_o  (data[g])
    );
  end

  assign in_ready  = rdy[0] & ~flush;
  assign out_valid = vld[DEPTH-1];
  assign out_data  = data[DEPTH-1];
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(accept) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
